// File: rtl/sync_fifo.sv
// sync_fifo: single-clock DEPTH x DATA_WIDTH FIFO; clk_i, async active-low rst_i, wr_en_i/wdata_i, rd_en_i -> registered rdata_o, full_o/empty_o, overflow_o/underflow_o pulses, count_o when SYNC_FIFO_COUNT_EN
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 12,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
`ifdef SYNC_FIFO_COUNT_EN
  output logic [PTR_WIDTH:0]    count_o,
`endif
  output logic                  underflow_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty_o = wr_ptr == rd_ptr;
  assign full_o = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) && (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_en_i);
`ifdef SYNC_FIFO_COUNT_EN
  assign count_o = wr_ptr - rd_ptr;
`endif
  always_ff @(posedge clk_i)
    if (wr_ok && rst_i) mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata_o <= '0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{PTR_WIDTH{1'b0}}, wr_ok};
      rd_ptr <= rd_ptr + {{PTR_WIDTH{1'b0}}, rd_ok};
      if (rd_ok) rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]];
      overflow_o <= wr_en_i && full_o && !rd_en_i;
      underflow_o <= rd_en_i && empty_o;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with a queue reference model checked every cycle
module tb_sync_fifo;
  localparam int DEPTH = 16;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic wr_en_i = 1'b0;
  logic rd_en_i = 1'b0;
  logic [11:0] wdata_i = '0;
  logic [11:0] rdata_o;
  logic full_o, empty_o, overflow_o, underflow_o;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0] count_o;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [11:0] q [$];
  logic [11:0] exp_rdata;
  logic exp_ovf, exp_unf;
  logic [11:0] w [16];

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o),
`ifdef SYNC_FIFO_COUNT_EN
    .count_o(count_o),
`endif
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q.delete();
      exp_rdata = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      automatic bit was_empty = q.size() == 0;
      automatic bit was_full = q.size() == DEPTH;
      exp_unf = rd_en_i && was_empty;
      exp_ovf = wr_en_i && was_full && !rd_en_i;
      if (rd_en_i && !was_empty) exp_rdata = q.pop_front();
      if (wr_en_i && (!was_full || rd_en_i)) q.push_back(wdata_i);
    end
  end

  always @(negedge clk_i) begin
    chk("empty", empty_o, q.size() == 0);
    chk("full", full_o, q.size() == DEPTH);
    chk("rdata", rdata_o, exp_rdata);
    chk("overflow", overflow_o, exp_ovf);
    chk("underflow", underflow_o, exp_unf);
`ifdef SYNC_FIFO_COUNT_EN
    chk("count", count_o, q.size());
`endif
  end

  task automatic cyc(input logic wr, input logic rd, input logic [11:0] d);
    wr_en_i = wr;
    rd_en_i = rd;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("t1 reset empty", empty_o, 1);
    chk("t1 reset rdata", rdata_o, 0);
    rst_i = 1'b1;
    cyc(1, 0, 12'h123);
    chk("t1 empty after write", empty_o, 0);
    cyc(0, 1, 0);
    chk("t1 rdata", rdata_o, 12'h123);
    chk("t1 empty after read", empty_o, 1);
    for (int i = 0; i < 5; i++) begin
      w[i] = 12'($urandom);
      cyc(1, 0, w[i]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      chk("t2 rdata", rdata_o, w[i]);
      chk("t2 no underflow", underflow_o, 0);
    end
    for (int i = 0; i < 16; i++) begin
      w[i] = 12'($urandom_range(0, 12'hABB));
      cyc(1, 0, w[i]);
    end
    chk("t3 full", full_o, 1);
    cyc(1, 0, 12'hABC);
    chk("t3 overflow pulse", overflow_o, 1);
    chk("t3 still full", full_o, 1);
    cyc(0, 0, 0);
    chk("t3 overflow cleared", overflow_o, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0);
      chk("t3 rdata", rdata_o, w[i]);
    end
    chk("t3 empty", empty_o, 1);
    for (int i = 0; i < 16; i++) begin
      w[i] = 12'($urandom);
      cyc(1, 0, w[i]);
    end
    for (int i = 0; i < 16; i++) cyc(0, 1, 0);
    chk("t4 empty", empty_o, 1);
    cyc(0, 1, 0);
    chk("t4 underflow pulse", underflow_o, 1);
    chk("t4 rdata held", rdata_o, w[15]);
    cyc(0, 0, 0);
    chk("t4 underflow cleared", underflow_o, 0);
    cyc(1, 1, 12'h5A5);
    chk("t5 rw-empty underflow", underflow_o, 1);
    chk("t5 rw-empty write kept", empty_o, 0);
    cyc(0, 1, 0);
    chk("t5 rw-empty data", rdata_o, 12'h5A5);
    for (int i = 0; i < 16; i++) begin
      w[i] = 12'($urandom);
      cyc(1, i > 0, w[i]);
      if (i > 0) chk("t5 stream rdata", rdata_o, w[i-1]);
      #($urandom_range(5, 8));
      @(posedge clk_i);
      #1;
    end
    cyc(0, 1, 0);
    chk("t5 last rdata", rdata_o, w[15]);
    chk("t5 drained", empty_o, 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 12'(i + 'h300));
    chk("t6 not empty", empty_o, 0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6 async empty", empty_o, 1);
    chk("t6 async rdata", rdata_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc(1, 0, 12'h7E1);
    cyc(0, 1, 0);
    chk("t6 round trip", rdata_o, 12'h7E1);
    chk("t6 empty", empty_o, 1);
    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
